adder_share_arbiter: RTL and testbench

//  Shares one 32-bit BrentKung adder between NREQ requesters using round-robin arbitration.

---
 rtl/adder_share_pkg.sv | 10 +
 rtl/BrentKung.sv | 35 +++
 rtl/adder_share_arbiter_rr.sv | 23 ++
 rtl/adder_share_arbiter.sv | 76 +++++++
 tb/tb_adder_share_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: adder width and response record shared by the adder arbiter slice.
package adder_share_pkg;
    localparam int ADD_W = 32;
    localparam int MAX_IDW = 3;
    typedef struct packed {
        logic [MAX_IDW-1:0] id;
        logic               cout;
        logic [ADD_W-1:0]   sum;
    } rsp_t;
endpackage

// File: rtl/BrentKung.sv
// BrentKung: parallel-prefix adder using a Brent-Kung up-sweep/down-sweep carry tree.
module BrentKung #(
    parameter int W = 32
) (
    input  logic [W-1:0] inputA,
    input  logic [W-1:0] inputB,
    input  logic         carryin,
    output logic [W-1:0] sum,
    output logic         carryOut
);
    logic [W-1:0] halfSum, grpG, grpP, carry;
    always_comb begin
        halfSum = inputA ^ inputB;
        grpG = inputA & inputB;
        grpP = halfSum;
        for (int d = 1; d < W; d *= 2)
            for (int i = 0; i < W; i++)
                if (i % (2 * d) == 2 * d - 1) begin
                    grpG[i] = grpG[i] | (grpP[i] & grpG[i - d]);
                    grpP[i] = grpP[i] & grpP[i - d];
                end
        // down-sweep fills the prefixes the up-sweep skipped
        for (int d = W / 4; d >= 1; d /= 2)
            for (int i = 0; i < W; i++)
                if (i >= 3 * d - 1 && i % (2 * d) == d - 1) begin
                    grpG[i] = grpG[i] | (grpP[i] & grpG[i - d]);
                    grpP[i] = grpP[i] & grpP[i - d];
                end
        carry[0] = carryin;
        for (int i = 1; i < W; i++)
            carry[i] = grpG[i - 1] | (grpP[i - 1] & carryin);
        sum = halfSum ^ carry;
        carryOut = grpG[W - 1] | (grpP[W - 1] & carryin);
    end
endmodule

// File: rtl/adder_share_arbiter_rr.sv
// rr_arbiter: round-robin grant, first requester at or above rrPtr wins, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] request,
    input  logic            enable,
    input  logic [IDW-1:0]  rrPtr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grantId
);
    always_comb begin
        grant = '0;
        grantId = '0;
        // descending scan so the closest requester to rrPtr is written last
        for (int k = NREQ - 1; k >= 0; k--)
            if (enable && request[(int'(rrPtr) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(rrPtr) + k) % NREQ] = 1'b1;
                grantId = IDW'((int'(rrPtr) + k) % NREQ);
            end
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: shares one BrentKung adder among NREQ requesters through
// a round-robin granted operand stage and a backpressured response stage.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_cout
);
    logic [ADD_W-1:0] opA, opB, addSum;
    logic             opCin, opValid, addCout, s1Take, s2Take, accept;
    logic [IDW-1:0]   opId, rrPtr, grantId;
    rsp_t             rspReg;

    assign s2Take = !rsp_valid || rsp_ready;
    assign s1Take = !opValid || s2Take;
    assign accept = |(req_valid & req_ready);

    rr_arbiter #(.NREQ(NREQ)) arb (
        .request(req_valid),
        .enable (s1Take && !rst),
        .rrPtr  (rrPtr),
        .grant  (req_ready),
        .grantId(grantId)
    );

    BrentKung #(.W(ADD_W)) adder (
        .inputA  (opA),
        .inputB  (opB),
        .carryin (opCin),
        .sum     (addSum),
        .carryOut(addCout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opValid <= 1'b0;
            opA <= '0;
            opB <= '0;
            opCin <= 1'b0;
            opId <= '0;
            rrPtr <= '0;
            rsp_valid <= 1'b0;
            rspReg <= '0;
        end else begin
            if (s1Take) opValid <= accept;
            if (accept) begin
                opA <= req_a[ADD_W*grantId+:ADD_W];
                opB <= req_b[ADD_W*grantId+:ADD_W];
                opCin <= req_cin[grantId];
                opId <= grantId;
                rrPtr <= IDW'((int'(grantId) + 1) % NREQ);
            end
            if (s2Take) begin
                rsp_valid <= opValid;
                rspReg <= '{id: MAX_IDW'(opId), cout: addCout, sum: addSum};
            end
        end
    end

    assign rsp_id = rspReg.id[IDW-1:0];
    assign rsp_sum = rspReg.sum;
    assign rsp_cout = rspReg.cout;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed vectors for the shared-adder arbiter (NREQ=4).
module tb_adder_share_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_cin = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    int vecs = 0;
    int errs = 0;

    adder_share_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[32*i+:32] = a;
        req_b[32*i+:32] = b;
        req_cin[i] = c;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready} !== '0) begin
            errs++;
            $display("FAIL reset_state: got v=%b id=%0d sum=%h c=%b rdy=%b, want all 0", rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready);
        end
        rst = 1'b0;
        set_op(2, 32'h1234_5678, 32'h1, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (rsp_valid !== 1'b1 || dut.opValid !== 1'b1) begin
            errs++;
            $display("FAIL reset_prefill: got rsp_valid=%b op_valid=%b, want 1 1", rsp_valid, dut.opValid);
        end
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready} !== '0) begin
            errs++;
            $display("FAIL reset_async: got v=%b id=%0d sum=%h c=%b rdy=%b, want all 0", rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++;
            if (rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL reset_no_rsp: cycle %0d got rsp_valid=%b, want 0", k, rsp_valid);
            end
        end
        req_valid = 4'b1111;
        #1;
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++;
            $display("FAIL reset_first_grant: got %b, want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_single();
        set_op(1, 32'h8902_8902, 32'h1111_1111, 1'b1);
        req_valid = 4'b0010;
        #1;
        vecs++;
        if (req_ready !== 4'b0010) begin
            errs++;
            $display("FAIL single_ready: got %b, want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        vecs++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL single_latency: got rsp_valid=%b one edge after accept, want 0", rsp_valid);
        end
        @(negedge clk);
        vecs++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd1, 32'h9A13_9A14, 1'b0}) begin
            errs++;
            $display("FAIL single_rsp: got v=%b id=%0d sum=%h c=%b, want v=1 id=1 sum=9a139a14 c=0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        @(negedge clk);
    endtask

    task automatic test_carry();
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        set_op(0, 32'h0000_FFFF, 32'h0000_1111, 1'b1);
        @(negedge clk);
        req_valid = 4'b0000;
        vecs++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1}) begin
            errs++;
            $display("FAIL carry_all_ones: got v=%b id=%0d sum=%h c=%b, want v=1 id=0 sum=ffffffff c=1", rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        @(negedge clk);
        vecs++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd0, 32'h0001_1111, 1'b0}) begin
            errs++;
            $display("FAIL carry_ripple: got v=%b id=%0d sum=%h c=%b, want v=1 id=0 sum=00011111 c=0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] expAll [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] expPair [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        pulse_reset();
        for (int i = 0; i < 4; i++) set_op(i, 32'h100 * i, 32'h1, 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            vecs++;
            if (req_ready !== expAll[k]) begin
                errs++;
                $display("FAIL rr_all[%0d]: got %b, want %b", k, req_ready, expAll[k]);
            end
            if (k >= 2) begin
                vecs++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(k - 2)) begin
                    errs++;
                    $display("FAIL rr_rsp_id[%0d]: got v=%b id=%0d, want v=1 id=%0d", k, rsp_valid, rsp_id, k - 2);
                end
            end
            @(negedge clk);
        end
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            vecs++;
            if (req_ready !== expPair[k]) begin
                errs++;
                $display("FAIL rr_pair[%0d]: got %b, want %b", k, req_ready, expPair[k]);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0] expRdy [5] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 4; i++) set_op(i, 32'h10 * i, 32'h1, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            vecs++;
            if (req_ready !== expRdy[k]) begin
                errs++;
                $display("FAIL bp_ready[%0d]: got %b, want %b", k, req_ready, expRdy[k]);
            end
            if (k >= 2) begin
                vecs++;
                if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd3, 32'h31, 1'b0}) begin
                    errs++;
                    $display("FAIL bp_stable[%0d]: got v=%b id=%0d sum=%h c=%b, want v=1 id=3 sum=31 c=0", k, rsp_valid, rsp_id, rsp_sum, rsp_cout);
                end
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        vecs++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 32'h1}) begin
            errs++;
            $display("FAIL bp_second: got v=%b id=%0d sum=%h, want v=1 id=0 sum=1", rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
        vecs++;
        if (rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_no_dup: got rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        set_op(3, 32'h0000_FFFF, 32'h0000_1110, 1'b0);
        req_valid = 4'b1000;
        for (int k = 0; k < 11; k++) begin
            #1;
            if (k < 8) begin
                vecs++;
                if (req_ready !== 4'b1000) begin
                    errs++;
                    $display("FAIL b2b_ready[%0d]: got %b, want 1000", k, req_ready);
                end
            end
            if (k >= 2 && k <= 9) begin
                vecs++;
                if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd3, 32'h0001_110F, 1'b0}) begin
                    errs++;
                    $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d sum=%h c=%b, want v=1 id=3 sum=0001110f c=0", k, rsp_valid, rsp_id, rsp_sum, rsp_cout);
                end
            end
            if (rsp_valid) got++;
            @(negedge clk);
            if (k == 7) req_valid = 4'b0000;
        end
        vecs++;
        if (got !== 8) begin
            errs++;
            $display("FAIL b2b_count: got %0d responses, want 8", got);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
